// File: rtl/fm_access_seq_pkg.sv
// Shared types and helpers for the fast-memory access sequencer.
package fm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD
  } fm_state_t;

  localparam int FM_ADDR_W    = 4;
  localparam int FM_PAR_MAX_W = 64;

  // Bit that makes the total ones count (vector plus this bit) odd.
  function automatic logic odd_parity(input logic [FM_PAR_MAX_W-1:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/fm_access_seq_strobe_timer.sv
// Loadable down-counter timing the ACTIVE phase of a RAM access.
// tc is high while the count is zero; the count parks at zero.
module fm_strobe_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/fm_access_seq.sv
// Access sequencer for an mc10145 16x4 RAM bank: SETUP / ACTIVE / HOLD
// bracketing of the active-low enable and write strobes.
// Optional macro FM_ACCESS_SEQ_PARITY_EN adds an odd-parity column at
// bit WIDTH of the RAM word and a read parity-error flag.
module fm_access_seq
  import fm_pkg::*;
#(
  parameter int WIDTH     = 36,
  parameter int WR_PULSE  = 2,
  parameter int RD_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 req,
  input  logic                 we,
  input  logic [FM_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     rdata,
  output logic                 par_err,
  output logic [FM_ADDR_W-1:0] ram_a,
  output logic [WIDTH:0]       ram_d,
  output logic                 ram_nen,
  output logic                 ram_nwrite,
  input  logic [WIDTH:0]       ram_q
);

  localparam int MAX_CYC = (WR_PULSE > RD_CYCLES) ? WR_PULSE : RD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

  fm_state_t            state_q, state_d;
  logic                 we_q, we_d;
  logic [FM_ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [WIDTH:0]       ram_d_q, ram_d_d;
  logic                 ram_nen_q, ram_nen_d;
  logic                 ram_nwrite_q, ram_nwrite_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_tc;
  logic                 wpar;

`ifdef FM_ACCESS_SEQ_PARITY_EN
  logic par_err_q, par_err_d;
  assign wpar    = odd_parity(FM_PAR_MAX_W'(wdata));
  assign par_err = par_err_q;
`else
  logic unused_par_col;
  assign unused_par_col = ram_q[WIDTH];
  assign wpar           = 1'b0;
  assign par_err        = 1'b0;
`endif

  fm_strobe_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .nreset  (nreset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tc      (tmr_tc)
  );

  // Next-state and registered-output computation; strobes default inactive
  // so they are only low during ACTIVE, leaving SETUP/HOLD as guard cycles.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    ram_a_d      = ram_a_q;
    ram_d_d      = ram_d_q;
    ram_nen_d    = 1'b1;
    ram_nwrite_d = 1'b1;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
`ifdef FM_ACCESS_SEQ_PARITY_EN
    par_err_d    = par_err_q;
`endif
    tmr_load     = 1'b0;
    tmr_val      = we_q ? WR_LOAD : RD_LOAD;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          we_d    = we;
          ram_a_d = addr;
          ram_d_d = {wpar, wdata};
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        state_d      = ACTIVE;
        ram_nen_d    = 1'b0;
        ram_nwrite_d = ~we_q;
        tmr_load     = 1'b1;
      end
      ACTIVE: begin
        if (tmr_tc) begin
          state_d = HOLD;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = ram_q[WIDTH-1:0];
`ifdef FM_ACCESS_SEQ_PARITY_EN
            par_err_d = ~(^ram_q);
`endif
          end
        end else begin
          ram_nen_d    = 1'b0;
          ram_nwrite_d = ~we_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      ram_a_q      <= '0;
      ram_d_q      <= '0;
      ram_nen_q    <= 1'b1;
      ram_nwrite_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rdata_q      <= '0;
`ifdef FM_ACCESS_SEQ_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      ram_a_q      <= ram_a_d;
      ram_d_q      <= ram_d_d;
      ram_nen_q    <= ram_nen_d;
      ram_nwrite_q <= ram_nwrite_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
`ifdef FM_ACCESS_SEQ_PARITY_EN
      par_err_q    <= par_err_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign ram_a      = ram_a_q;
  assign ram_d      = ram_d_q;
  assign ram_nen    = ram_nen_q;
  assign ram_nwrite = ram_nwrite_q;

endmodule

// File: tb/tb_fm_access_seq.sv
// Directed bench for fm_access_seq with a behavioural mc10145 bank model.
module tb_fm_access_seq;

  localparam int WIDTH = 36;

`ifdef FM_ACCESS_SEQ_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             req = 1'b0;
  logic             we = 1'b0;
  logic [3:0]       addr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic             busy, done, par_err;
  logic [WIDTH-1:0] rdata;
  logic [3:0]       ram_a;
  logic [WIDTH:0]   ram_d, ram_q;
  logic             ram_nen, ram_nwrite;
  logic             flip_q0 = 1'b0;

  logic [WIDTH:0]   mem [16] = '{default: '0};
  logic [WIDTH-1:0] ref_mem [16] = '{default: '0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fm_access_seq #(
    .WIDTH    (WIDTH),
    .WR_PULSE (2),
    .RD_CYCLES(1)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .par_err   (par_err),
    .ram_a     (ram_a),
    .ram_d     (ram_d),
    .ram_nen   (ram_nen),
    .ram_nwrite(ram_nwrite),
    .ram_q     (ram_q)
  );

  // RAM bank: write while both strobes low, drive 0 when disabled.
  always @(posedge clk) begin
    if (!ram_nen && !ram_nwrite) mem[ram_a] <= ram_d;
  end
  always_comb begin
    ram_q = '0;
    if (!ram_nen) ram_q = mem[ram_a] ^ {{WIDTH{1'b0}}, flip_q0};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address/data must hold steady while the bank is enabled.
  logic        prev_low = 1'b0;
  logic [63:0] prev_ad  = '0;
  always @(negedge clk) begin
    if (!ram_nen && prev_low) check("addr_data_stable", {23'd0, ram_a, ram_d}, prev_ad);
    prev_low = !ram_nen;
    prev_ad  = {23'd0, ram_a, ram_d};
  end

  // One access; returns done latency (cycles after accept edge), strobe-low
  // cycle counts and the RAM data seen in the SETUP cycle.
  task automatic access(input logic w, input logic [3:0] a, input logic [WIDTH-1:0] d,
                        output int lat, output int nen_low, output int nwr_low,
                        output logic [WIDTH:0] d_setup);
    lat = 0; nen_low = 0; nwr_low = 0; d_setup = '0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 1) d_setup = ram_d;
      if (!ram_nen) nen_low++;
      if (!ram_nwrite) nwr_low++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lat, nl, nwl;
  logic [WIDTH:0] dsu;
  logic [63:0] rnd;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] last_rd;

  initial begin
    // Reset with req asserted
    req = 1'b1; we = 1'b1; addr = 4'd1; wdata = 36'hFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_nen", ram_nen, 1);
    check("rst_nwrite", ram_nwrite, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_par_err", par_err, 0);
    req = 1'b0;
    nreset = 1'b1;

    // Write then read addr 5
    access(1'b1, 4'd5, 36'h123456789, lat, nl, nwl, dsu);
    check("wr_lat", lat, 4);
    check("wr_nen_low", nl, 2);
    check("wr_nwr_low", nwl, 2);
    check("wr_busy_hold", busy, 1);
    ref_mem[5] = 36'h123456789;
    access(1'b0, 4'd5, '0, lat, nl, nwl, dsu);
    check("rd_lat", lat, 3);
    check("rd_nen_low", nl, 1);
    check("rd_nwr_low", nwl, 0);
    check("rd_data5", rdata, 36'h123456789);
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Busy rejection: req addr=3 during a write to addr=2
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 4'd2; wdata = 36'hA5A5A5A5A;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 4'd3; wdata = 36'h333333333;
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin lat = 1; break; end
      @(negedge clk);
    end
    check("busy_done_seen", lat, 1);
    @(negedge clk);
    @(negedge clk);
    check("busy_no_requeue", busy, 0);
    ref_mem[2] = 36'hA5A5A5A5A;
    access(1'b0, 4'd2, '0, lat, nl, nwl, dsu);
    check("busy_rd2", rdata, 36'hA5A5A5A5A);
    access(1'b0, 4'd3, '0, lat, nl, nwl, dsu);
    check("busy_rd3", rdata, 0);

    // 16 random writes, then read all words back
    for (int i = 0; i < 16; i++) begin
      rnd = {$urandom(), $urandom()};
      wd  = rnd[WIDTH-1:0];
      ref_mem[i] = wd;
      access(1'b1, 4'(i), wd, lat, nl, nwl, dsu);
      check("rand_wr_lat", lat, 4);
      check("rand_wr_dpar", dsu[WIDTH], PAR_EN ? {63'd0, ~(^wd)} : 64'd0);
    end
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 4'(i), '0, lat, nl, nwl, dsu);
      check("rand_rd", rdata, ref_mem[i]);
      check("rand_par_err", par_err, 0);
    end
    last_rd = rdata;

    // Reset during the ACTIVE phase of a write
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 4'd9; wdata = 36'h0ABCDEF01;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("midrst_active", ram_nen, 0);
    nreset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_nen", ram_nen, 1);
    check("midrst_nwrite", ram_nwrite, 1);
    check("midrst_busy", busy, 0);
    check("midrst_rdata", rdata, 0);
    @(negedge clk);
    nreset = 1'b1;
    access(1'b1, 4'd7, 36'hFFFFFFFFF, lat, nl, nwl, dsu);
    check("post_rst_wr_lat", lat, 4);
    check("rdata_hold_on_wr", rdata, 0);
    access(1'b0, 4'd7, '0, lat, nl, nwl, dsu);
    check("post_rst_rd7", rdata, 36'hFFFFFFFFF);

    // Parity column and error flag
    access(1'b1, 4'd12, 36'h000000001, lat, nl, nwl, dsu);
    check("par_col_wr1", dsu[WIDTH], 0);
    access(1'b1, 4'd13, 36'h000000003, lat, nl, nwl, dsu);
    check("par_col_wr3", dsu[WIDTH], PAR_EN ? 64'd1 : 64'd0);
    flip_q0 = 1'b1;
    access(1'b0, 4'd12, '0, lat, nl, nwl, dsu);
    flip_q0 = 1'b0;
    check("par_err_flip", par_err, PAR_EN ? 64'd1 : 64'd0);
    check("par_flip_rdata", rdata, 0);
    access(1'b1, 4'd1, 36'h000000F00, lat, nl, nwl, dsu);
    check("par_err_hold_wr", par_err, PAR_EN ? 64'd1 : 64'd0);
    access(1'b0, 4'd12, '0, lat, nl, nwl, dsu);
    check("par_err_clean", par_err, 0);
    check("par_clean_rdata", rdata, 36'h000000001);
    access(1'b0, 4'd13, '0, lat, nl, nwl, dsu);
    check("par_rd13", rdata, 36'h000000003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
